agu_pp: RTL and testbench
=========================

# agu_pp

Parametrised ping-pong address generation unit for the Bellman-Ford systolic array. It produces the per-column read and write addresses for the distance DRAMs, driven by the control unit enables and the phase-counter rollover strobes. Each completed write sweep closes one iteration; the unit swaps ping-pong banks, counts iterations and stops on convergence (no relaxation in a full iteration) or on a programmed iteration limit.

## Interface
- NUM_COLS, 16, columns per sweep; address wraps at NUM_COLS-1 (2..2^ADDR_W)
- ADDR_W, 10, address width (1024-deep DRAMs)
- ITER_W, 8, iteration counter width
- PP_EN, 1, 1 = bank toggling enabled; 0 = both bank outputs tied 0
- clk  in  1  single clock, all state on rising edge
- rst_global  in  1  synchronous, active-high reset
- start  in  1  level; sampled in IDLE/DONE to begin a run
- max_iter  in  ITER_W  iteration limit, sampled on start; 0 = unlimited
- read_enable_cu, write_enable_cu  in  1  CU address-advance requests
- pre_rollover_phase_counter, rollover_phase_counter  in  1  phase strobes, ORed into read/write enable
- changed  in  1  any PE relaxed a distance this cycle
- read_address, write_address  out  ADDR_W  DRAM addresses
- read_bank, write_bank  out  1  ping-pong bank selects
- iteration_done  out  1  one-cycle pulse per completed iteration
- iteration_count  out  ITER_W  completed iterations this run
- busy, done, converged  out  1  status

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE/DONE: start=1 -> RUN; clears iteration_count, converged, done, change accumulator; latches max_iter; sets read_bank=0, write_bank=PP_EN; addresses 0.
- RUN: rd_en = read_enable_cu | pre_rollover_phase_counter; wr_en = write_enable_cu | rollover_phase_counter. Enables ignored outside RUN.
- Read counter: rd_en and read_address==NUM_COLS-1 -> 0 and read_bank toggles (PP_EN=1); else rd_en -> +1; else hold.
- Write counter: same rule with wr_en, write_address, write_bank. Wrap happens only on an enabled cycle at NUM_COLS-1 (no early reset at terminal count).
- Read and write wrap independently; skew between them is legal and each bank select follows its own counter.
- Change accumulator: sticky OR of `changed` during RUN; at write wrap, iteration flag = acc | changed, acc cleared (changed on wrap cycle counts for closing iteration only).
- At write wrap: iteration_count +1 (modulo 2^ITER_W), iteration_done pulses next cycle.
- Termination at write wrap: flag==0 -> converged=1, DONE; else if max_iter!=0 and iteration_count+1==max_iter -> DONE (converged=0); else stay RUN.
- DONE: done=1, busy=0, addresses forced 0, counts and converged held until next start.
- start while RUN ignored. rst_global mid-run aborts to reset values next edge.
- Reset values: addresses 0, read_bank 0, write_bank 0, iteration_done 0, iteration_count 0, busy 0, done 0, converged 0.

## Timing
- start high at edge t (IDLE) -> busy=1 from t+1; enables at t+1 act on edge t+2.
- Address changes on the edge where its enable is sampled high; zero-latency enable-to-update.
- Bank toggle on same edge as its address wraps to 0.
- iteration_done high exactly one cycle, the cycle after the write-wrap edge; iteration_count updated on the wrap edge (already incremented while pulse high).
- done/converged assert on the wrap edge of final iteration (coincident with, and through, the final iteration_done pulse); busy drops same edge.
- busy = (state==RUN), combinational from state register.

## Test plan
- Reset, NUM_COLS=16: start, wr_en and rd_en held 1 with changed=1 every cycle, max_iter=3 -> addresses 0..15 repeating, iteration_done at cycles 17/33/49 after RUN entry, count 1,2,3, done=1 converged=0 with third pulse.
- Convergence: max_iter=0, changed=1 only during iteration 1 -> iteration 2 ends with converged=1, done=1, iteration_count=2.
- Bank skew: rd_en via pre_rollover one cycle ahead of wr_en via rollover -> read_bank toggles one cycle before write_bank; banks always opposite after both wraps with PP_EN=1; both 0 with PP_EN=0.
- Hold/boundary: enables low at address 15 for 5 cycles -> address holds 15, no wrap, no pulse; enable at 15 -> 0 next edge with pulse.
- changed only on write-wrap cycle -> that iteration counts as changed, next iteration without change converges.
- rst_global asserted mid-iteration at write_address 7 -> all outputs reset values next edge, IDLE; start ignored while RUN, restart from DONE clears count.

Source files
------------

// File: rtl/agu_pp_if.sv
// rtl/agu_pp_if.sv - control/status bundle between the control unit and the ping-pong AGU
interface agu_pp_if #(
    parameter int ADDR_W = 10,
    parameter int ITER_W = 8
);
    logic              start;
    logic [ITER_W-1:0] max_iter;
    logic              read_enable_cu;
    logic              write_enable_cu;
    logic              pre_rollover_phase_counter;
    logic              rollover_phase_counter;
    logic              changed;
    logic [ADDR_W-1:0] read_address;
    logic [ADDR_W-1:0] write_address;
    logic              read_bank;
    logic              write_bank;
    logic              iteration_done;
    logic [ITER_W-1:0] iteration_count;
    logic              busy;
    logic              done;
    logic              converged;

    modport slave (
        input  start, max_iter, read_enable_cu, write_enable_cu,
               pre_rollover_phase_counter, rollover_phase_counter, changed,
        output read_address, write_address, read_bank, write_bank,
               iteration_done, iteration_count, busy, done, converged
    );

    modport master (
        output start, max_iter, read_enable_cu, write_enable_cu,
               pre_rollover_phase_counter, rollover_phase_counter, changed,
        input  read_address, write_address, read_bank, write_bank,
               iteration_done, iteration_count, busy, done, converged
    );
endinterface

// File: rtl/agu_pp.sv
// rtl/agu_pp.sv - ping-pong read/write address generator with iteration and convergence tracking
module agu_pp #(
    parameter int NUM_COLS = 16,
    parameter int ADDR_W   = 10,
    parameter int ITER_W   = 8,
    parameter int PP_EN    = 1
) (
    input  logic      clk,
    input  logic      rst_global,
    agu_pp_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_COLS - 1);
    localparam logic              PP_BIT    = (PP_EN != 0);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              rd_bank_q, rd_bank_d;
    logic              wr_bank_q, wr_bank_d;
    logic              acc_q, acc_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [ITER_W-1:0] max_q, max_d;
    logic              conv_q, conv_d;
    logic              iter_done_q, iter_done_d;

    logic              run;
    logic              rd_en;
    logic              wr_en;
    logic              rd_wrap;
    logic              wr_wrap;
    logic              iter_flag;
    logic [ITER_W-1:0] cnt_inc;

    assign run       = (state_q == S_RUN);
    assign rd_en     = run & (bus.read_enable_cu | bus.pre_rollover_phase_counter);
    assign wr_en     = run & (bus.write_enable_cu | bus.rollover_phase_counter);
    assign rd_wrap   = rd_en & (rd_addr_q == LAST_ADDR);
    assign wr_wrap   = wr_en & (wr_addr_q == LAST_ADDR);
    // A change reported on the wrap cycle itself still belongs to the closing iteration.
    assign iter_flag = acc_q | bus.changed;
    assign cnt_inc   = cnt_q + ITER_W'(1);

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        rd_bank_d   = rd_bank_q;
        wr_bank_d   = wr_bank_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        conv_d      = conv_q;
        iter_done_d = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d   = S_RUN;
                    rd_addr_d = '0;
                    wr_addr_d = '0;
                    rd_bank_d = 1'b0;
                    wr_bank_d = PP_BIT;
                    acc_d     = 1'b0;
                    cnt_d     = '0;
                    conv_d    = 1'b0;
                    max_d     = bus.max_iter;
                end
            end
            S_RUN: begin
                if (rd_wrap) begin
                    rd_addr_d = '0;
                    rd_bank_d = PP_BIT & ~rd_bank_q;
                end else if (rd_en) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end

                if (wr_wrap) begin
                    wr_addr_d = '0;
                    wr_bank_d = PP_BIT & ~wr_bank_q;
                end else if (wr_en) begin
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                end

                acc_d = acc_q | bus.changed;
                if (wr_wrap) begin
                    acc_d       = 1'b0;
                    cnt_d       = cnt_inc;
                    iter_done_d = 1'b1;
                    if (!iter_flag) begin
                        conv_d  = 1'b1;
                        state_d = S_DONE;
                    end else if ((max_q != '0) && (cnt_inc == max_q)) begin
                        state_d = S_DONE;
                    end
                end

                // Addresses park at zero for the whole DONE stay.
                if (state_d == S_DONE) begin
                    rd_addr_d = '0;
                    wr_addr_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_global) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            rd_bank_q   <= 1'b0;
            wr_bank_q   <= 1'b0;
            acc_q       <= 1'b0;
            cnt_q       <= '0;
            max_q       <= '0;
            conv_q      <= 1'b0;
            iter_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            rd_bank_q   <= rd_bank_d;
            wr_bank_q   <= wr_bank_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            conv_q      <= conv_d;
            iter_done_q <= iter_done_d;
        end
    end

    assign bus.read_address    = rd_addr_q;
    assign bus.write_address   = wr_addr_q;
    assign bus.read_bank       = rd_bank_q;
    assign bus.write_bank      = wr_bank_q;
    assign bus.iteration_done  = iter_done_q;
    assign bus.iteration_count = cnt_q;
    assign bus.busy            = run;
    assign bus.done            = (state_q == S_DONE);
    assign bus.converged       = conv_q;
endmodule

// File: tb/tb_agu_pp.sv
// tb/tb_agu_pp.sv - directed bench for agu_pp with an iteration_done scoreboard
module tb_agu_pp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    agu_pp_if #(.ADDR_W(10), .ITER_W(8)) bus ();
    agu_pp_if #(.ADDR_W(2),  .ITER_W(4)) bus2 ();

    agu_pp #(.NUM_COLS(16), .ADDR_W(10), .ITER_W(8), .PP_EN(1)) dut (
        .clk(clk), .rst_global(rst), .bus(bus)
    );
    agu_pp #(.NUM_COLS(4), .ADDR_W(2), .ITER_W(4), .PP_EN(0)) dut2 (
        .clk(clk), .rst_global(rst), .bus(bus2)
    );

    typedef struct {
        int cnt;
        bit done;
        bit conv;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rd_cu, input bit wr_cu, input bit pre, input bit roll, input bit chg);
        bus.read_enable_cu             = rd_cu;
        bus.write_enable_cu            = wr_cu;
        bus.pre_rollover_phase_counter = pre;
        bus.rollover_phase_counter     = roll;
        bus.changed                    = chg;
    endtask

    task automatic push(input int cnt, input bit dn, input bit cv);
        exp_t e;
        e.cnt  = cnt;
        e.done = dn;
        e.conv = cv;
        sb.push_back(e);
    endtask

    // Every iteration_done pulse must match the next queued expectation.
    always begin
        @(posedge clk);
        #1;
        if (bus.iteration_done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_count", 32'(bus.iteration_count), 32'(mon_e.cnt));
                chk("pulse_done",  32'(bus.done),            32'(mon_e.done));
                chk("pulse_conv",  32'(bus.converged),       32'(mon_e.conv));
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.max_iter = '0;
        drive(0, 0, 0, 0, 0);
        bus2.start = 1'b0;
        bus2.max_iter = '0;
        bus2.read_enable_cu = 1'b0;
        bus2.write_enable_cu = 1'b0;
        bus2.pre_rollover_phase_counter = 1'b0;
        bus2.rollover_phase_counter = 1'b0;
        bus2.changed = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_raddr", 32'(bus.read_address), 32'd0);
        chk("rst_waddr", 32'(bus.write_address), 32'd0);
        chk("rst_rbank", 32'(bus.read_bank), 32'd0);
        chk("rst_wbank", 32'(bus.write_bank), 32'd0);
        chk("rst_idone", 32'(bus.iteration_done), 32'd0);
        chk("rst_count", 32'(bus.iteration_count), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_conv",  32'(bus.converged), 32'd0);

        // Full-rate run limited to three iterations
        bus.max_iter = 8'd3;
        bus.start = 1'b1;
        drive(1, 1, 0, 0, 1);
        tick();
        bus.start = 1'b0;
        chk("t1_busy",  32'(bus.busy), 32'd1);
        chk("t1_rbank", 32'(bus.read_bank), 32'd0);
        chk("t1_wbank", 32'(bus.write_bank), 32'd1);
        chk("t1_waddr0", 32'(bus.write_address), 32'd0);
        push(1, 0, 0);
        push(2, 0, 0);
        push(3, 1, 0);
        for (int k = 1; k <= 48; k++) begin
            tick();
            if (k < 48) begin
                chk("t1_waddr", 32'(bus.write_address), 32'(k % 16));
                chk("t1_raddr", 32'(bus.read_address), 32'(k % 16));
            end
            if (k == 16) begin
                chk("t1_rbank_wrap", 32'(bus.read_bank), 32'd1);
                chk("t1_wbank_wrap", 32'(bus.write_bank), 32'd0);
            end
        end
        chk("t1_done",  32'(bus.done), 32'd1);
        chk("t1_busy0", 32'(bus.busy), 32'd0);
        chk("t1_conv",  32'(bus.converged), 32'd0);
        chk("t1_count", 32'(bus.iteration_count), 32'd3);
        chk("t1_waddr_done", 32'(bus.write_address), 32'd0);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("t1_done_hold",  32'(bus.done), 32'd1);
        chk("t1_count_hold", 32'(bus.iteration_count), 32'd3);
        chk("t1_pulse_once", 32'(bus.iteration_done), 32'd0);

        // Convergence: changes only during the first iteration
        bus.max_iter = 8'd0;
        bus.start = 1'b1;
        drive(1, 1, 0, 0, 1);
        tick();
        bus.start = 1'b0;
        chk("t2_count0", 32'(bus.iteration_count), 32'd0);
        chk("t2_done0",  32'(bus.done), 32'd0);
        chk("t2_busy",   32'(bus.busy), 32'd1);
        push(1, 0, 0);
        push(2, 1, 1);
        for (int k = 1; k <= 32; k++) begin
            bus.changed = (k <= 16);
            tick();
        end
        chk("t2_conv",  32'(bus.converged), 32'd1);
        chk("t2_done",  32'(bus.done), 32'd1);
        chk("t2_count", 32'(bus.iteration_count), 32'd2);
        chk("t2_busy0", 32'(bus.busy), 32'd0);

        // Change seen only on the write-wrap cycle
        bus.start = 1'b1;
        drive(1, 1, 0, 0, 0);
        tick();
        bus.start = 1'b0;
        chk("t3_count_cleared", 32'(bus.iteration_count), 32'd0);
        chk("t3_conv_cleared",  32'(bus.converged), 32'd0);
        push(1, 0, 0);
        push(2, 1, 1);
        for (int k = 1; k <= 32; k++) begin
            bus.changed = (k == 16);
            tick();
        end
        chk("t3_conv",  32'(bus.converged), 32'd1);
        chk("t3_count", 32'(bus.iteration_count), 32'd2);

        // Hold at terminal address, start ignored while running
        bus.start = 1'b1;
        drive(1, 1, 0, 0, 1);
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 15; k++) tick();
        chk("t4_waddr15", 32'(bus.write_address), 32'd15);
        chk("t4_raddr15", 32'(bus.read_address), 32'd15);
        drive(0, 0, 0, 0, 1);
        bus.max_iter = 8'd1;
        bus.start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_hold_waddr", 32'(bus.write_address), 32'd15);
            chk("t4_hold_pulse", 32'(bus.iteration_done), 32'd0);
            chk("t4_hold_count", 32'(bus.iteration_count), 32'd0);
        end
        bus.start = 1'b0;
        push(1, 0, 0);
        drive(1, 1, 0, 0, 1);
        tick();
        chk("t4_wrap_waddr", 32'(bus.write_address), 32'd0);
        chk("t4_wrap_raddr", 32'(bus.read_address), 32'd0);
        chk("t4_wrap_rbank", 32'(bus.read_bank), 32'd1);
        chk("t4_wrap_wbank", 32'(bus.write_bank), 32'd0);
        chk("t4_still_busy", 32'(bus.busy), 32'd1);

        // Read side leads write side by one cycle via the phase strobes
        drive(0, 0, 1, 0, 1);
        tick();
        chk("t5_raddr1", 32'(bus.read_address), 32'd1);
        chk("t5_waddr0", 32'(bus.write_address), 32'd0);
        drive(0, 0, 1, 1, 1);
        repeat (14) tick();
        chk("t5_raddr15", 32'(bus.read_address), 32'd15);
        chk("t5_waddr14", 32'(bus.write_address), 32'd14);
        tick();
        chk("t5_rwrap_addr",  32'(bus.read_address), 32'd0);
        chk("t5_rwrap_rbank", 32'(bus.read_bank), 32'd0);
        chk("t5_rwrap_wbank", 32'(bus.write_bank), 32'd0);
        chk("t5_waddr15",     32'(bus.write_address), 32'd15);
        push(2, 0, 0);
        drive(0, 0, 0, 1, 1);
        tick();
        chk("t5_wwrap_addr",  32'(bus.write_address), 32'd0);
        chk("t5_wwrap_wbank", 32'(bus.write_bank), 32'd1);
        chk("t5_wwrap_rbank", 32'(bus.read_bank), 32'd0);
        chk("t5_raddr_hold",  32'(bus.read_address), 32'd0);

        // Reset in the middle of an iteration
        repeat (7) tick();
        chk("t6_waddr7", 32'(bus.write_address), 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy",  32'(bus.busy), 32'd0);
        chk("t6_waddr", 32'(bus.write_address), 32'd0);
        chk("t6_wbank", 32'(bus.write_bank), 32'd0);
        chk("t6_rbank", 32'(bus.read_bank), 32'd0);
        chk("t6_count", 32'(bus.iteration_count), 32'd0);
        chk("t6_done",  32'(bus.done), 32'd0);
        chk("t6_idone", 32'(bus.iteration_done), 32'd0);
        tick();
        chk("t6_idle_waddr", 32'(bus.write_address), 32'd0);
        chk("t6_idle_busy",  32'(bus.busy), 32'd0);
        drive(0, 0, 0, 0, 0);

        // Bank toggling disabled on the second instance
        bus2.max_iter = 4'd2;
        bus2.start = 1'b1;
        bus2.read_enable_cu = 1'b1;
        bus2.write_enable_cu = 1'b1;
        bus2.changed = 1'b1;
        tick();
        bus2.start = 1'b0;
        chk("t7_wbank_start", 32'(bus2.write_bank), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t7_rbank", 32'(bus2.read_bank), 32'd0);
            chk("t7_wbank", 32'(bus2.write_bank), 32'd0);
            if (k < 8) chk("t7_raddr", 32'(bus2.read_address), 32'(k % 4));
        end
        chk("t7_done",  32'(bus2.done), 32'd1);
        chk("t7_count", 32'(bus2.iteration_count), 32'd2);

        tick();
        #2;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
